// File: rtl/ar_txd.sv
// ARINC 429 word transmitter: latches label/data on a start strobe, appends odd
// parity and drives the 32-bit word as bipolar return-to-zero on two unipolar rails.
module ar_txd #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  Nvel,
    input  logic [7:0]  ADR,
    input  logic [22:0] DAT,
    input  logic        st,
    output logic        TXD0,
    output logic        TXD1
);

    // Half-bit lengths in clocks for 12.5 / 50 / 100 / 200 kbps.
    localparam int unsigned HALF_0 = CLK_HZ / 25_000;
    localparam int unsigned HALF_1 = CLK_HZ / 100_000;
    localparam int unsigned HALF_2 = CLK_HZ / 200_000;
    localparam int unsigned HALF_3 = CLK_HZ / 400_000;
    localparam int unsigned CW     = $clog2(HALF_0 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      rate_q, rate_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      idx_q, idx_d;
    logic            phase_q, phase_d;
    logic            txd0_q, txd0_d;
    logic            txd1_q, txd1_d;

    logic [CW-1:0]   half_len;
    logic            half_end;
    logic            gap_end;

    // Word stored in transmission order: bit 0 goes out first.
    function automatic logic [31:0] build_word(input logic [7:0] adr, input logic [22:0] dat);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i] = adr[7-i];
        end
        w[30:8] = dat;
        w[31]   = ~^{adr, dat};
        return w;
    endfunction

    always_comb begin
        half_len = CW'(HALF_0);
        case (rate_q)
            2'd0:    half_len = CW'(HALF_0);
            2'd1:    half_len = CW'(HALF_1);
            2'd2:    half_len = CW'(HALF_2);
            default: half_len = CW'(HALF_3);
        endcase
    end

    assign half_end = (cnt_q == half_len - CW'(1));
    // The gap is one clock short of 4 bit periods so that, with the registered
    // rails lagging the state by one clock, consecutive words start 36 bit periods apart.
    assign gap_end  = (idx_q == 5'd7) && (cnt_q == half_len - CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            txd0_q  <= 1'b0;
            txd1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            txd0_q  <= txd0_d;
            txd1_q  <= txd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (st) begin
                    state_d = SEND;
                    word_d  = build_word(ADR, DAT);
                    rate_d  = Nvel;
                    cnt_d   = '0;
                    idx_d   = '0;
                    phase_d = 1'b0;
                end
            end
            SEND: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        word_d  = {1'b0, word_q[31:1]};
                        if (idx_q == 5'd31) begin
                            state_d = GAP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (half_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        txd0_d = 1'b0;
        txd1_d = 1'b0;
        if (state_q == SEND && !phase_q) begin
            txd1_d = word_q[0];
            txd0_d = ~word_q[0];
        end
    end

    assign TXD0 = txd0_q;
    assign TXD1 = txd1_q;

endmodule

// File: tb/tb_ar_txd.sv
// Bench for ar_txd: random words checked half-bit by half-bit against a model
// built from the ARINC word rules (label MSB first, data LSB first, odd parity).
module tb_ar_txd;

    localparam int unsigned HZ_A = 2_000_000;
    localparam int unsigned HZ_B = 50_000_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st = 1'b0;
    logic [1:0]  nvel = 2'd0;
    logic [7:0]  adr = 8'd0;
    logic [22:0] dat = 23'd0;
    logic        a0, a1, b0, b1;
    logic        sel_b = 1'b0;
    logic        r0, r1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign r0 = sel_b ? b0 : a0;
    assign r1 = sel_b ? b1 : a1;

    ar_txd #(.CLK_HZ(HZ_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .Nvel(nvel), .ADR(adr), .DAT(dat), .st(st),
        .TXD0(a0), .TXD1(a1)
    );

    ar_txd #(.CLK_HZ(HZ_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .Nvel(nvel), .ADR(adr), .DAT(dat), .st(st),
        .TXD0(b0), .TXD1(b1)
    );

    function automatic int half_of(input int unsigned hz, input logic [1:0] nv);
        int unsigned rate;
        case (nv)
            2'd0:    rate = 12_500;
            2'd1:    rate = 50_000;
            2'd2:    rate = 100_000;
            default: rate = 200_000;
        endcase
        return int'(hz / (2 * rate));
    endfunction

    // Bit i (0-based) of the transmitted sequence.
    function automatic logic exp_bit(input logic [7:0] a, input logic [22:0] d, input int i);
        if (i < 8) return a[7-i];
        else if (i < 31) return d[i-8];
        else return (($countones({a, d}) % 2) == 0);
    endfunction

    task automatic start_word(input logic [7:0] a, input logic [22:0] d, input logic [1:0] nv,
                              input bit hold);
        @(negedge clk);
        adr = a;
        dat = d;
        nvel = nv;
        st = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) st = 1'b0;
    endtask

    // dist_kind: 1 = pulse st at dist_k, 2 = scramble inputs at dist_k, 3 = drop st at dist_k.
    task automatic check_word(input logic [7:0] a, input logic [22:0] d, input int h,
                              input int stop_k, input int dist_k, input int dist_kind,
                              input string name);
        int last;
        int bad_k;
        int bi;
        int ph;
        logic b;
        logic e0, e1;
        logic [1:0] got, want;
        last = (stop_k > 0) ? stop_k : 64 * h;
        bad_k = 0;
        got = 2'b00;
        want = 2'b00;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (k == dist_k) begin
                case (dist_kind)
                    1: st = 1'b1;
                    2: begin
                        adr = 8'($urandom);
                        dat = 23'($urandom);
                        nvel = 2'($urandom);
                    end
                    3: st = 1'b0;
                    default: ;
                endcase
            end
            if (dist_kind == 1 && k == dist_k + 1) st = 1'b0;
            bi = (k - 1) / (2 * h);
            ph = (k - 1) % (2 * h);
            b = exp_bit(a, d, bi);
            e1 = (ph < h) && b;
            e0 = (ph < h) && !b;
            if ({r1, r0} !== {e1, e0} && bad_k == 0) begin
                bad_k = k;
                got = {r1, r0};
                want = {e1, e0};
            end
            if (ph == 2 * h - 1) begin
                checks++;
                if (bad_k != 0) begin
                    errors++;
                    $display("FAIL %s bit %0d: rails {TXD1,TXD0}=%b at cycle %0d, expected %b",
                             name, bi + 1, got, bad_k, want);
                end
                bad_k = 0;
            end
        end
    endtask

    task automatic check_null(input int n, input string name);
        int bad_k;
        logic [1:0] got;
        bad_k = 0;
        got = 2'b00;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if ({r1, r0} !== 2'b00 && bad_k == 0) begin
                bad_k = k;
                got = {r1, r0};
            end
        end
        checks++;
        if (bad_k != 0) begin
            errors++;
            $display("FAIL %s: rails {TXD1,TXD0}=%b at cycle %0d, expected 00", name, got, bad_k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        adr = 8'($urandom);
        dat = 23'($urandom);
        st = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a1, a0, b1, b0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rails: got %b, expected 0000", {a1, a0, b1, b0});
        end
        rst_n = 1'b1;
        check_null(40, "idle_after_reset");
    endtask

    task automatic test_reference();
        sel_b = 1'b1;
        start_word(8'h8D, 23'h702D00, 2'd2, 1'b0);
        check_word(8'h8D, 23'h702D00, 250, 0, 0, 0, "reference_word");
        check_null(2000, "reference_gap");
        sel_b = 1'b0;
    endtask

    task automatic test_parity();
        logic [1:0] nv;
        int h;
        nv = 2'($urandom_range(1, 3));
        h = half_of(HZ_A, nv);
        start_word(8'h01, 23'h0, nv, 1'b0);
        check_word(8'h01, 23'h0, h, 0, 0, 0, "parity_one_label_bit");
        check_null(8 * h, "parity_gap_a");
        start_word(8'h00, 23'h0, nv, 1'b0);
        check_word(8'h00, 23'h0, h, 0, 0, 0, "parity_all_zero");
        check_null(8 * h, "parity_gap_b");
    endtask

    task automatic test_rates();
        logic [7:0] a;
        logic [22:0] d;
        int h;
        for (int nv = 0; nv < 4; nv++) begin
            a = 8'($urandom);
            d = 23'($urandom);
            h = half_of(HZ_A, 2'(nv));
            start_word(a, d, 2'(nv), 1'b0);
            check_word(a, d, h, 0, 0, 0, $sformatf("rate_nvel%0d", nv));
            check_null(8 * h, $sformatf("rate_gap_nvel%0d", nv));
        end
    endtask

    task automatic test_busy();
        logic [7:0] a;
        logic [22:0] d;
        logic [1:0] nv;
        int h;
        a = 8'($urandom);
        d = 23'($urandom);
        nv = 2'($urandom);
        h = half_of(HZ_A, nv);
        start_word(a, d, nv, 1'b0);
        check_word(a, d, h, 0, 10 * h + 3, 1, "busy_st_pulse");
        check_null(8 * h, "busy_gap");
        check_null(4 * h, "busy_no_queued_word");
    endtask

    task automatic test_input_stability();
        logic [7:0] a;
        logic [22:0] d;
        logic [1:0] nv;
        int h;
        a = 8'($urandom);
        d = 23'($urandom);
        nv = 2'($urandom);
        h = half_of(HZ_A, nv);
        start_word(a, d, nv, 1'b0);
        check_word(a, d, h, 0, 5 * h, 2, "stability_inputs_changed");
        check_null(8 * h, "stability_gap");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [22:0] d;
        logic [1:0] nv;
        int h;
        a = 8'($urandom);
        d = 23'($urandom);
        nv = 2'($urandom_range(1, 3));
        h = half_of(HZ_A, nv);
        start_word(a, d, nv, 1'b1);
        check_word(a, d, h, 0, 0, 0, "b2b_first");
        check_null(8 * h, "b2b_gap");
        check_word(a, d, h, 0, 1, 3, "b2b_second");
        check_null(8 * h, "b2b_final_gap");
        check_null(2 * h, "b2b_no_third_word");
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        logic [22:0] d;
        logic [1:0] nv;
        logic b;
        int h;
        a = 8'($urandom);
        d = 23'($urandom);
        nv = 2'($urandom_range(1, 3));
        h = half_of(HZ_A, nv);
        start_word(a, d, nv, 1'b0);
        check_word(a, d, h, 18 * h + 2, 0, 0, "reset_mid_prefix");
        b = exp_bit(a, d, 9);
        checks++;
        if ({r1, r0} !== {b, !b}) begin
            errors++;
            $display("FAIL reset_mid_bit10_active: got %b, expected %b", {r1, r0}, {b, !b});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r1, r0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_async_clear: got %b, expected 00", {r1, r0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_null(6 * h, "reset_mid_idle_after_release");
        a = 8'($urandom);
        d = 23'($urandom);
        start_word(a, d, nv, 1'b0);
        check_word(a, d, h, 0, 0, 0, "reset_mid_new_word");
        check_null(8 * h, "reset_mid_gap");
    endtask

    initial begin
        test_reset();
        test_reference();
        test_parity();
        test_rates();
        test_busy();
        test_input_stability();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
